// File: rtl/tsu_pkg.sv
// Shared definitions for the TSU timestamp queue path.
//   tsu_arb_state_e : queue-arbiter FSM states
//   SRC_RX / SRC_TX : record source tags carried on ts_src
//   TS_REC_W        : width of one timestamp record, shared with tsu
package tsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } tsu_arb_state_e;

  localparam logic SRC_RX = 1'b0;
  localparam logic SRC_TX = 1'b1;

  localparam int unsigned TS_REC_W = 64;

endpackage

// File: rtl/tsu_queue_arb.sv
// Round-robin arbiter and read sequencer draining the RX and TX tsu timestamp queues into a
// single valid/ready record stream.
//
// Parameters:
//   RD_LAT : cycles from q_rd_en to valid q_rd_data on a tsu queue (legal 1..4)
//   CNT_W  : width of the per-source grant counters (wrap silently)
// Ports:
//   q_rd_clk                  : single clock, shared with both tsu queue read ports
//   rst                       : synchronous active-high reset
//   rx_q_rd_stat/tx_q_rd_stat : queue fill counts, non-zero means a record is available
//   rx_q_rd_data/tx_q_rd_data : queue read data
//   rx_q_rd_en/tx_q_rd_en     : single-cycle read strobes (registered)
//   ts_valid/ts_ready         : output handshake
//   ts_data/ts_src            : captured record and its source (0 = RX, 1 = TX)
//   rx_grant_cnt/tx_grant_cnt : number of reads issued per source
module tsu_queue_arb
  import tsu_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                q_rd_clk,
  input  logic                rst,
  input  logic [7:0]          rx_q_rd_stat,
  input  logic [TS_REC_W-1:0] rx_q_rd_data,
  output logic                rx_q_rd_en,
  input  logic [7:0]          tx_q_rd_stat,
  input  logic [TS_REC_W-1:0] tx_q_rd_data,
  output logic                tx_q_rd_en,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [TS_REC_W-1:0] ts_data,
  output logic                ts_src,
  output logic [CNT_W-1:0]    rx_grant_cnt,
  output logic [CNT_W-1:0]    tx_grant_cnt
);

  // Latency counter start value; a 2-bit counter covers RD_LAT up to 4.
  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  tsu_arb_state_e      state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_src_q, last_src_d;
  logic [1:0]          lat_q, lat_d;
  logic                rx_rd_en_q, rx_rd_en_d;
  logic                tx_rd_en_q, tx_rd_en_d;
  logic                ts_valid_q, ts_valid_d;
  logic [TS_REC_W-1:0] ts_data_q, ts_data_d;
  logic                ts_src_q, ts_src_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;

  logic req_rx;
  logic req_tx;
  logic grant_src;

  assign req_rx = (rx_q_rd_stat != 8'd0);
  assign req_tx = (tx_q_rd_stat != 8'd0);

  // On a tie the source that was not served last wins; otherwise the lone requester.
  always_comb begin
    grant_src = SRC_RX;
    if (req_rx && req_tx) begin
      grant_src = ~last_src_q;
    end else if (req_tx) begin
      grant_src = SRC_TX;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_src_d = last_src_q;
    lat_d      = lat_q;
    rx_rd_en_d = 1'b0;
    tx_rd_en_d = 1'b0;
    ts_valid_d = ts_valid_q;
    ts_data_d  = ts_data_q;
    ts_src_d   = ts_src_q;
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_rx || req_tx) begin
          sel_d   = grant_src;
          state_d = StIssue;
          // Strobe is registered, so it is high exactly for the ISSUE cycle.
          rx_rd_en_d = (grant_src == SRC_RX);
          tx_rd_en_d = (grant_src == SRC_TX);
        end
      end

      StIssue: begin
        if (sel_q == SRC_TX) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
        lat_d   = LatInit;
        state_d = StWait;
      end

      StWait: begin
        if (lat_q == 2'd0) begin
          ts_data_d  = (sel_q == SRC_TX) ? tx_q_rd_data : rx_q_rd_data;
          ts_src_d   = sel_q;
          last_src_d = sel_q;
          ts_valid_d = 1'b1;
          state_d    = StHold;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      StHold: begin
        if (ts_ready) begin
          ts_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge q_rd_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= SRC_RX;
      last_src_q <= SRC_TX;  // RX wins the first tie after reset
      lat_q      <= 2'd0;
      rx_rd_en_q <= 1'b0;
      tx_rd_en_q <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_data_q  <= '0;
      ts_src_q   <= SRC_RX;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_src_q <= last_src_d;
      lat_q      <= lat_d;
      rx_rd_en_q <= rx_rd_en_d;
      tx_rd_en_q <= tx_rd_en_d;
      ts_valid_q <= ts_valid_d;
      ts_data_q  <= ts_data_d;
      ts_src_q   <= ts_src_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign rx_q_rd_en   = rx_rd_en_q;
  assign tx_q_rd_en   = tx_rd_en_q;
  assign ts_valid     = ts_valid_q;
  assign ts_data      = ts_data_q;
  assign ts_src       = ts_src_q;
  assign rx_grant_cnt = rx_cnt_q;
  assign tx_grant_cnt = tx_cnt_q;

endmodule

// File: tb/tb_tsu_queue_arb.sv
// Bench for tsu_queue_arb. Instance A uses RD_LAT=1/CNT_W=16, instance B uses
// RD_LAT=3/CNT_W=4. Each of the four queues (A.rx, A.tx, B.rx, B.tx) is a small model
// of a tsu read port: stat decrements on a read, data appears RD_LAT cycles later.
module tb_tsu_queue_arb;

  typedef struct {
    logic        src;
    logic [63:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic q_load;
  logic ready_a, ready_b;

  always #5 clk = ~clk;

  // Queue model state, index q = inst*2 + src.
  logic [63:0] mem      [4][32];
  logic [7:0]  init_cnt [4];
  logic [7:0]  cnt      [4];
  logic [4:0]  ptr      [4];
  logic [63:0] pipe     [4][4];
  int          en_count [4];
  logic [3:0]  rd_en_v;

  logic        a_rx_en, a_tx_en, a_ts_valid, a_ts_src;
  logic [63:0] a_ts_data;
  logic [15:0] a_rx_cnt, a_tx_cnt;
  logic        b_rx_en, b_tx_en, b_ts_valid, b_ts_src;
  logic [63:0] b_ts_data;
  logic [3:0]  b_rx_cnt, b_tx_cnt;

  assign rd_en_v = {b_tx_en, b_rx_en, a_tx_en, a_rx_en};

  always @(posedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (q_load) begin
        ptr[q]      <= 5'd0;
        cnt[q]      <= init_cnt[q];
        en_count[q] <= 0;
        for (int k = 0; k < 4; k++) pipe[q][k] <= 64'd0;
      end else begin
        if (rd_en_v[q]) begin
          pipe[q][0]  <= mem[q][ptr[q]];
          ptr[q]      <= ptr[q] + 5'd1;
          if (cnt[q] != 8'd0) cnt[q] <= cnt[q] - 8'd1;
          en_count[q] <= en_count[q] + 1;
        end
        for (int k = 1; k < 4; k++) pipe[q][k] <= pipe[q][k-1];
      end
    end
  end

  tsu_queue_arb #(.RD_LAT(1), .CNT_W(16)) u_dut_a (
    .q_rd_clk    (clk),
    .rst         (rst),
    .rx_q_rd_stat(cnt[0]),
    .rx_q_rd_data(pipe[0][0]),
    .rx_q_rd_en  (a_rx_en),
    .tx_q_rd_stat(cnt[1]),
    .tx_q_rd_data(pipe[1][0]),
    .tx_q_rd_en  (a_tx_en),
    .ts_valid    (a_ts_valid),
    .ts_ready    (ready_a),
    .ts_data     (a_ts_data),
    .ts_src      (a_ts_src),
    .rx_grant_cnt(a_rx_cnt),
    .tx_grant_cnt(a_tx_cnt)
  );

  tsu_queue_arb #(.RD_LAT(3), .CNT_W(4)) u_dut_b (
    .q_rd_clk    (clk),
    .rst         (rst),
    .rx_q_rd_stat(cnt[2]),
    .rx_q_rd_data(pipe[2][2]),
    .rx_q_rd_en  (b_rx_en),
    .tx_q_rd_stat(cnt[3]),
    .tx_q_rd_data(pipe[3][2]),
    .tx_q_rd_en  (b_tx_en),
    .ts_valid    (b_ts_valid),
    .ts_ready    (ready_b),
    .ts_data     (b_ts_data),
    .ts_src      (b_ts_src),
    .rx_grant_cnt(b_rx_cnt),
    .tx_grant_cnt(b_tx_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a valid record on instance inst, sampled on the falling edge.
  task automatic get_rec(input int inst, output logic got, output logic src,
                         output logic [63:0] data);
    got  = 1'b0;
    src  = 1'b0;
    data = 64'd0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if ((inst == 0) ? a_ts_valid : b_ts_valid) begin
        got  = 1'b1;
        src  = (inst == 0) ? a_ts_src : b_ts_src;
        data = (inst == 0) ? a_ts_data : b_ts_data;
      end
    end
  endtask

  // Reset both instances and reload all queue models from mem/init_cnt.
  task automatic reload();
    @(negedge clk);
    rst    = 1'b1;
    q_load = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    q_load = 1'b0;
  endtask

  task automatic load_tab(input int inst, input rec_t tab[]);
    int ix[2];
    ix = '{0, 0};
    foreach (tab[i]) begin
      int s;
      s = int'(tab[i].src);
      mem[inst*2+s][ix[s]] = tab[i].data;
      ix[s]++;
    end
    init_cnt[inst*2]   = 8'(ix[0]);
    init_cnt[inst*2+1] = 8'(ix[1]);
  endtask

  rec_t single_tab[] = '{
    '{1'b0, 64'hAAAA_0000_0000_000A},
    '{1'b0, 64'hBBBB_0000_0000_000B},
    '{1'b0, 64'hCCCC_0000_0000_000C}
  };
  // Expected output order under contention: RX, TX, RX, TX.
  rec_t cont_tab[] = '{
    '{1'b0, 64'h1111_0000_0000_0001},
    '{1'b1, 64'h2222_0000_0000_0002},
    '{1'b0, 64'h3333_0000_0000_0003},
    '{1'b1, 64'h4444_0000_0000_0004}
  };
  rec_t bp_tab[] = '{
    '{1'b0, 64'h5050_5050_0000_0050},
    '{1'b1, 64'h6060_6060_0000_0060},
    '{1'b0, 64'h7070_7070_0000_0070},
    '{1'b1, 64'h8080_8080_0000_0080}
  };

  initial begin
    logic        got, src;
    logic [63:0] data;
    logic        stable;
    int          t_en, t_v;

    rst     = 1'b1;
    q_load  = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int q = 0; q < 4; q++) init_cnt[q] = 8'd0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_valid", a_ts_valid, 1'b0);
    chk("rst_rx_en", a_rx_en, 1'b0);
    chk("rst_tx_en", a_tx_en, 1'b0);
    chk("rst_data", a_ts_data, 64'd0);
    chk("rst_src", a_ts_src, 1'b0);
    chk("rst_rx_cnt", a_rx_cnt, 16'd0);
    chk("rst_tx_cnt", a_tx_cnt, 16'd0);
    chk("rst_b_valid", b_ts_valid, 1'b0);

    // Single source
    load_tab(0, single_tab);
    reload();
    for (int i = 0; i < single_tab.size(); i++) begin
      get_rec(0, got, src, data);
      chk($sformatf("single_got%0d", i), got, 1'b1);
      chk($sformatf("single_src%0d", i), src, single_tab[i].src);
      chk($sformatf("single_data%0d", i), data, single_tab[i].data);
    end
    repeat (4) @(negedge clk);
    chk("single_rx_cnt", a_rx_cnt, 16'd3);
    chk("single_tx_en_pulses", en_count[1], 0);

    // Contention
    load_tab(0, cont_tab);
    reload();
    for (int i = 0; i < cont_tab.size(); i++) begin
      get_rec(0, got, src, data);
      chk($sformatf("cont_got%0d", i), got, 1'b1);
      chk($sformatf("cont_src%0d", i), src, cont_tab[i].src);
      chk($sformatf("cont_data%0d", i), data, cont_tab[i].data);
    end
    repeat (4) @(negedge clk);
    chk("cont_rx_cnt", a_rx_cnt, 16'd2);
    chk("cont_tx_cnt", a_tx_cnt, 16'd2);

    // Backpressure: first RX record is held for 20 cycles with no further reads
    load_tab(0, bp_tab);
    ready_a = 1'b0;
    reload();
    get_rec(0, got, src, data);
    chk("bp_got", got, 1'b1);
    chk("bp_src", src, 1'b0);
    chk("bp_data", data, bp_tab[0].data);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!a_ts_valid || a_ts_data !== bp_tab[0].data || a_ts_src !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_pulses", en_count[0] + en_count[1], 1);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("bp_after_hs_valid", a_ts_valid, 1'b0);
    chk("bp_after_hs_pulses", en_count[0] + en_count[1], 1);
    get_rec(0, got, src, data);
    chk("bp2_got", got, 1'b1);
    chk("bp2_src", src, 1'b1);
    chk("bp2_data", data, bp_tab[1].data);

    // Reset while holding the TX record; queues keep one record each
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", a_ts_valid, 1'b0);
    chk("mid_rst_rx_cnt", a_rx_cnt, 16'd0);
    chk("mid_rst_tx_cnt", a_tx_cnt, 16'd0);
    rst     = 1'b0;
    ready_a = 1'b1;
    get_rec(0, got, src, data);
    chk("post_rst_got", got, 1'b1);
    chk("post_rst_src", src, 1'b0);
    chk("post_rst_data", data, bp_tab[2].data);
    get_rec(0, got, src, data);
    chk("post_rst2_src", src, 1'b1);
    chk("post_rst2_data", data, bp_tab[3].data);

    // Latency, RD_LAT = 3
    for (int q = 0; q < 4; q++) init_cnt[q] = 8'd0;
    init_cnt[3] = 8'd1;
    mem[3][0]   = 64'h0123_4567_89AB_CDEF;
    reload();
    t_en = -1;
    t_v  = -1;
    for (int c = 0; c < 40 && t_v < 0; c++) begin
      @(negedge clk);
      if (t_en < 0 && b_tx_en) t_en = c;
      if (t_en >= 0 && b_ts_valid) begin
        t_v  = c;
        data = b_ts_data;
        src  = b_ts_src;
      end
    end
    chk("lat_seen", (t_en >= 0 && t_v >= 0), 1'b1);
    chk("lat_cycles", 64'(t_v - t_en), 64'd4);
    chk("lat_data", data, 64'h0123_4567_89AB_CDEF);
    chk("lat_src", src, 1'b1);

    // Wrap: 17 RX reads on a 4-bit counter
    init_cnt[3] = 8'd0;
    init_cnt[2] = 8'd17;
    for (int k = 0; k < 17; k++) mem[2][k] = 64'hB000 + 64'(k);
    reload();
    for (int k = 0; k < 17; k++) begin
      get_rec(1, got, src, data);
      chk($sformatf("wrap_data%0d", k), data, 64'hB000 + 64'(k));
    end
    repeat (4) @(negedge clk);
    chk("wrap_pulses", en_count[2], 17);
    chk("wrap_rx_cnt", b_rx_cnt, 4'd1);
    chk("wrap_tx_cnt", b_tx_cnt, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
